modexp_controller: RTL and testbench

MODEXP_CONTROLLER -- requirements
Module: modexp_controller

---
 rtl/modexp_controller.sv | 181 ++++++++++++++++++
 tb/tb_modexp_controller.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/modexp_controller.sv
// Left-to-right square-and-multiply sequencer for a modular exponentiation
// datapath. It walks the latched exponent from its highest set bit down to
// bit 0 and issues one datapath op at a time, waiting for dp_ack on each.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   start        request a new exponentiation (honoured only when idle)
//   exponent     exponent value, captured when start is accepted
//   abort        synchronous cancel of a running operation
//   dp_ack       datapath completion of the currently enabled op
//   busy         high whenever the controller is not idle
//   initialize   one-cycle datapath init pulse
//   en_square    request result <= result*result
//   en_multiply  request result <= result*base
//   en_modulo    request result <= result mod n
//   done         one-cycle pulse, result valid
//   error        one-cycle pulse, dp_ack timeout
//   bit_idx      exponent bit currently processed
module modexp_controller #(
  parameter int unsigned EXP_WIDTH = 16,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [EXP_WIDTH-1:0]         exponent,
  input  logic                         abort,
  input  logic                         dp_ack,
  output logic                         busy,
  output logic                         initialize,
  output logic                         en_square,
  output logic                         en_multiply,
  output logic                         en_modulo,
  output logic                         done,
  output logic                         error,
  output logic [$clog2(EXP_WIDTH)-1:0] bit_idx
);

  localparam int unsigned IDX_W = $clog2(EXP_WIDTH);
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    INIT    = 3'd1,
    SQUARE  = 3'd2,
    SQ_MOD  = 3'd3,
    MULT    = 3'd4,
    MUL_MOD = 3'd5,
    DONE    = 3'd6
  } state_t;

  state_t               state, state_nxt;
  logic [EXP_WIDTH-1:0] exp_q;
  logic [CNT_W-1:0]     wait_cnt;
  logic [IDX_W-1:0]     idx_nxt;
  logic [IDX_W-1:0]     msb_idx;
  logic                 load_exp;
  logic                 timeout_hit;
  logic                 op_state;

  // Position of the most significant set bit of the latched exponent.
  always_comb begin
    msb_idx = '0;
    for (int unsigned i = 0; i < EXP_WIDTH; i++) begin
      if (exp_q[i]) msb_idx = IDX_W'(i);
    end
  end

  assign op_state = (state == SQUARE) || (state == SQ_MOD) ||
                    (state == MULT)   || (state == MUL_MOD);

  // Next-state, bit index and control decode.
  always_comb begin
    state_nxt   = state;
    idx_nxt     = bit_idx;
    load_exp    = 1'b0;
    timeout_hit = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          load_exp  = 1'b1;
          state_nxt = INIT;
        end
      end
      INIT: begin
        idx_nxt = msb_idx;
        // The square of the initial 1 is pointless, so go straight to MULT.
        state_nxt = (exp_q == '0) ? DONE : MULT;
      end
      SQUARE: begin
        if (dp_ack) state_nxt = SQ_MOD;
      end
      SQ_MOD: begin
        if (dp_ack) begin
          if (exp_q[bit_idx]) begin
            state_nxt = MULT;
          end else if (bit_idx == '0) begin
            state_nxt = DONE;
          end else begin
            idx_nxt   = bit_idx - IDX_W'(1);
            state_nxt = SQUARE;
          end
        end
      end
      MULT: begin
        if (dp_ack) state_nxt = MUL_MOD;
      end
      MUL_MOD: begin
        if (dp_ack) begin
          if (bit_idx == '0) begin
            state_nxt = DONE;
          end else begin
            idx_nxt   = bit_idx - IDX_W'(1);
            state_nxt = SQUARE;
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    // Ack in the last allowed cycle still wins over the timeout.
    if (op_state && !dp_ack && (wait_cnt == CNT_LAST)) begin
      timeout_hit = 1'b1;
      state_nxt   = IDLE;
      idx_nxt     = bit_idx;
    end

    // Abort overrides everything while busy.
    if (abort && (state != IDLE)) begin
      timeout_hit = 1'b0;
      state_nxt   = IDLE;
      idx_nxt     = bit_idx;
    end
  end

  // State, exponent, index and wait counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      exp_q    <= '0;
      bit_idx  <= '0;
      wait_cnt <= '0;
    end else begin
      state   <= state_nxt;
      bit_idx <= idx_nxt;
      if (load_exp) exp_q <= exponent;
      // Cleared on every state change, so each op state starts counting at 0.
      if (!op_state || (state_nxt != state)) wait_cnt <= '0;
      else                                   wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  // Outputs registered from the next state so they line up with the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy        <= 1'b0;
      initialize  <= 1'b0;
      en_square   <= 1'b0;
      en_multiply <= 1'b0;
      en_modulo   <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
    end else begin
      busy        <= (state_nxt != IDLE);
      initialize  <= (state_nxt == INIT);
      en_square   <= (state_nxt == SQUARE);
      en_multiply <= (state_nxt == MULT);
      en_modulo   <= (state_nxt == SQ_MOD) || (state_nxt == MUL_MOD);
      done        <= (state_nxt == DONE);
      error       <= timeout_hit;
    end
  end

endmodule

// File: tb/tb_modexp_controller.sv
// Directed bench for modexp_controller with EXP_WIDTH=8, TIMEOUT=16.
module tb_modexp_controller;

  localparam int unsigned EW = 8;
  localparam int unsigned TO = 16;

  // Output vector layout: {busy, initialize, en_square, en_multiply, en_modulo, done, error}
  localparam logic [6:0] O_IDLE = 7'b0000000;
  localparam logic [6:0] O_INIT = 7'b1100000;
  localparam logic [6:0] O_SQ   = 7'b1010000;
  localparam logic [6:0] O_MUL  = 7'b1001000;
  localparam logic [6:0] O_MOD  = 7'b1000100;
  localparam logic [6:0] O_DONE = 7'b1000010;
  localparam logic [6:0] O_ERR  = 7'b0000001;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [EW-1:0] exponent;
  logic          abort;
  logic          dp_ack;
  logic          busy, initialize, en_square, en_multiply, en_modulo, done, error;
  logic [2:0]    bit_idx;
  logic [6:0]    outs;

  int checks = 0;
  int errors = 0;

  modexp_controller #(.EXP_WIDTH(EW), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .exponent   (exponent),
    .abort      (abort),
    .dp_ack     (dp_ack),
    .busy       (busy),
    .initialize (initialize),
    .en_square  (en_square),
    .en_multiply(en_multiply),
    .en_modulo  (en_modulo),
    .done       (done),
    .error      (error),
    .bit_idx    (bit_idx)
  );

  assign outs = {busy, initialize, en_square, en_multiply, en_modulo, done, error};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, expv, $time);
    end
  endtask

  // Steps through a run; idx entries < 0 mean bit_idx is not checked that cycle.
  task automatic run_seq(input string tag, input logic [6:0] seq[$], input int idx[$],
                         input logic [EW-1:0] junk);
    for (int i = 0; i < seq.size(); i++) begin
      step();
      if (i == 0) begin
        start    = 1'b0;
        exponent = junk;
      end
      chk($sformatf("%s_out%0d", tag, i), 16'(outs), 16'(seq[i]));
      if (idx[i] >= 0) chk($sformatf("%s_idx%0d", tag, i), 16'(bit_idx), 16'(idx[i]));
    end
  endtask

  initial begin
    logic [6:0] seq[$];
    int         idx[$];
    logic [2:0] en, en_rec;
    int         k, ops, dones, done_at, cyc;
    logic       finished;

    rst_n    = 1'b0;
    start    = 1'b0;
    exponent = '0;
    abort    = 1'b0;
    dp_ack   = 1'b0;

    // Reset state
    #1;
    chk("reset_out", 16'(outs), 16'(O_IDLE));
    chk("reset_idx", 16'(bit_idx), 16'd0);
    #11 rst_n = 1'b1;

    // Exponent 0: init then done immediately, start on first edge after reset
    exponent = 8'h00;
    start    = 1'b1;
    seq = '{O_INIT, O_DONE, O_IDLE};
    idx = '{-1, -1, -1};
    run_seq("e00", seq, idx, 8'h00);

    // Exponent 5 with constant ack; exponent input scrambled while busy
    exponent = 8'h05;
    start    = 1'b1;
    dp_ack   = 1'b1;
    seq = '{O_INIT, O_MUL, O_MOD, O_SQ, O_MOD, O_SQ, O_MOD, O_MUL, O_MOD, O_DONE, O_IDLE};
    idx = '{-1, 2, 2, 1, 1, 0, 0, 0, 0, -1, -1};
    run_seq("e05", seq, idx, 8'hFF);

    // Exponent 0x80 with ack on the 4th cycle of every op
    dp_ack   = 1'b0;
    exponent = 8'h80;
    start    = 1'b1;
    step();
    start = 1'b0;
    chk("e80_init", 16'(outs), 16'(O_INIT));
    k = 0; ops = 0; dones = 0; done_at = 0; cyc = 1; en_rec = '0; finished = 1'b0;
    for (int c = 0; c < 200; c++) begin
      step();
      cyc++;
      if (!busy) begin
        finished = 1'b1;
        break;
      end
      if (done) begin
        dones++;
        done_at = cyc;
      end
      en = {en_square, en_multiply, en_modulo};
      if (en != '0) begin
        chk("e80_onehot", 16'($countones(en)), 16'd1);
        k++;
        if (k == 1) en_rec = en;
        else        chk("e80_hold", 16'(en), 16'(en_rec));
        if (k == 4) begin
          dp_ack = 1'b1;
          ops++;
          k = 0;
        end else begin
          dp_ack = 1'b0;
        end
      end else begin
        dp_ack = 1'b0;
      end
    end
    dp_ack = 1'b0;
    chk("e80_finished", 16'(finished), 16'd1);
    chk("e80_ops", 16'(ops), 16'd16);
    chk("e80_dones", 16'(dones), 16'd1);
    chk("e80_done_at", 16'(done_at), 16'd66);

    // Timeout: ack never arrives during the first multiply
    exponent = 8'h01;
    start    = 1'b1;
    step();
    start = 1'b0;
    chk("tmo_init", 16'(outs), 16'(O_INIT));
    for (int i = 0; i < 16; i++) begin
      step();
      chk($sformatf("tmo_mul%0d", i), 16'(outs), 16'(O_MUL));
    end
    chk("tmo_idx", 16'(bit_idx), 16'd0);
    step();
    chk("tmo_err", 16'(outs), 16'(O_ERR));
    step();
    chk("tmo_idle", 16'(outs), 16'(O_IDLE));

    // Asynchronous reset during SQ_MOD, then a clean 0x03 run
    exponent = 8'h02;
    start    = 1'b1;
    dp_ack   = 1'b1;
    seq = '{O_INIT, O_MUL, O_MOD, O_SQ, O_MOD};
    idx = '{-1, 1, 1, 0, 0};
    run_seq("rst_pre", seq, idx, 8'h02);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_out", 16'(outs), 16'(O_IDLE));
    chk("rst_mid_idx", 16'(bit_idx), 16'd0);
    #3 rst_n = 1'b1;
    exponent = 8'h03;
    start    = 1'b1;
    seq = '{O_INIT, O_MUL, O_MOD, O_SQ, O_MOD, O_MUL, O_MOD, O_DONE, O_IDLE};
    idx = '{-1, 1, 1, 0, 0, 0, 0, -1, -1};
    run_seq("e03", seq, idx, 8'h00);

    // Start while busy is ignored; abort beats dp_ack during MULT
    dp_ack   = 1'b0;
    exponent = 8'h05;
    start    = 1'b1;
    step();
    start = 1'b0;
    chk("abt_init", 16'(outs), 16'(O_INIT));
    step();
    chk("abt_mul0", 16'(outs), 16'(O_MUL));
    start    = 1'b1;
    exponent = 8'h00;
    step();
    chk("abt_mul1", 16'(outs), 16'(O_MUL));
    start  = 1'b0;
    abort  = 1'b1;
    dp_ack = 1'b1;
    step();
    chk("abt_idle", 16'(outs), 16'(O_IDLE));
    abort  = 1'b0;
    dp_ack = 1'b0;
    step();
    chk("abt_stay", 16'(outs), 16'(O_IDLE));

    // Abort together with start in IDLE: start wins
    abort    = 1'b1;
    start    = 1'b1;
    exponent = 8'h00;
    step();
    chk("as_init", 16'(outs), 16'(O_INIT));
    abort = 1'b0;
    start = 1'b0;
    step();
    chk("as_done", 16'(outs), 16'(O_DONE));
    step();
    chk("as_idle", 16'(outs), 16'(O_IDLE));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
